spi_mnrch_gen: RTL and testbench

//  Parametrised SPI monarch: next generation of the single-slave 16-bit SPI master.

---
 rtl/spi_mnrch_gen.sv | 160 ++++++++++++++++
 tb/tb_spi_mnrch_gen.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mnrch_gen.sv
// spi_mnrch_gen: parametrised SPI monarch, DATA_W-bit full-duplex frames
// to one of NUM_SS slaves, SCLK = clk/2^DIV_LOG2, idle high.
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   wrt, wrt_data    start pulse and transmit word (IDLE/HOLD only)
//   ss_sel, keep_ss  slave index (IDLE only), hold SS_N after frame
//   MISO             serial data from slave
//   SCLK, MOSI, SS_N serial clock, data to slave, active-low selects
//   busy, done       frame in flight, frame finished (sticky)
//   rd_data          received word, valid while done=1
module spi_mnrch_gen #(
   parameter int DATA_W    = 16,
   parameter int DIV_LOG2  = 4,
   parameter int NUM_SS    = 1,
   parameter int LSB_FIRST = 0,
   localparam int SSW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wrt,
   input  logic [DATA_W-1:0] wrt_data,
   input  logic [SSW-1:0]    ss_sel,
   input  logic              keep_ss,
   input  logic              MISO,
   output logic              SCLK,
   output logic              MOSI,
   output logic [NUM_SS-1:0] SS_N,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rd_data
);

   localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DIV_LOG2-1:0] LD   = {2'b10, {(DIV_LOG2-2){1'b1}}};
   localparam logic [DIV_LOG2-1:0] SMPL = {1'b0, {(DIV_LOG2-1){1'b1}}};
   localparam logic [BCW-1:0]      LAST = BCW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FRONT, S_SHIFT, S_BACK, S_HOLD
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [DIV_LOG2-1:0] r_div;
   logic [DATA_W-1:0]   r_sr;
   logic [BCW-1:0]      r_bit_cnt;
   logic [NUM_SS-1:0]   r_ss_n;
   logic                r_done;
   logic                r_keep;
   logic                r_miso_smpl;

   logic                w_smpl;
   logic                w_shft_im;
   logic                w_last;
   logic                w_start;
   logic                w_shft;
   logic                w_finish;
   logic                w_div_ld;
   logic [NUM_SS-1:0]   w_ss_dec;
   logic [DATA_W-1:0]   w_sr_nxt;

   assign w_smpl    = (r_div == SMPL);
   assign w_shft_im = &r_div;
   assign w_last    = (r_bit_cnt == LAST);

   // Out-of-range indices match no line, so the frame runs unselected.
   always_comb begin
      w_ss_dec = '1;
      for (int i = 0; i < NUM_SS; i++) begin
         if (ss_sel == SSW'(i)) w_ss_dec[i] = 1'b0;
      end
   end

   generate
      if (LSB_FIRST != 0) begin : g_lsb
         assign w_sr_nxt = {r_miso_smpl, r_sr[DATA_W-1:1]};
         assign MOSI     = r_sr[0];
      end else begin : g_msb
         assign w_sr_nxt = {r_sr[DATA_W-2:0], r_miso_smpl};
         assign MOSI     = r_sr[DATA_W-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_start  = 1'b0;
      w_shft   = 1'b0;
      w_finish = 1'b0;
      w_div_ld = 1'b0;
      unique case (r_state)
         S_IDLE, S_HOLD: begin
            w_div_ld = 1'b1;
            if (wrt) begin
               w_start = 1'b1;
               w_next  = S_FRONT;
            end
         end
         S_FRONT: begin
            if (w_shft_im) w_next = S_SHIFT;
         end
         S_SHIFT: begin
            w_shft = w_shft_im;
            if (w_last) w_next = S_BACK;
         end
         S_BACK: begin
            if (w_shft_im) begin
               w_shft   = 1'b1;
               w_finish = 1'b1;
               w_div_ld = 1'b1;
               w_next   = r_keep ? S_HOLD : S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div       <= LD;
         r_sr        <= '0;
         r_bit_cnt   <= '0;
         r_ss_n      <= '1;
         r_done      <= 1'b0;
         r_keep      <= 1'b0;
         r_miso_smpl <= 1'b0;
      end else begin
         r_div <= w_div_ld ? LD : r_div + DIV_LOG2'(1);
         if (w_smpl) r_miso_smpl <= MISO;
         if (w_start) begin
            r_sr      <= wrt_data;
            r_bit_cnt <= '0;
            r_keep    <= keep_ss;
            r_done    <= 1'b0;
            // A burst continuation keeps the slave already selected.
            if (r_state == S_IDLE) r_ss_n <= w_ss_dec;
         end else if (w_shft) begin
            r_sr      <= w_sr_nxt;
            r_bit_cnt <= r_bit_cnt + BCW'(1);
         end
         if (w_finish) begin
            r_done <= 1'b1;
            if (!r_keep) r_ss_n <= '1;
         end
      end
   end

   assign SCLK    = r_div[DIV_LOG2-1];
   assign SS_N    = r_ss_n;
   assign busy    = (r_state == S_FRONT) || (r_state == S_SHIFT) ||
                    (r_state == S_BACK);
   assign done    = r_done;
   assign rd_data = r_sr;

endmodule

// File: tb/tb_spi_mnrch_gen.sv
// tb_spi_mnrch_gen: randomized bench for spi_mnrch_gen, two configurations
// (16-bit MSB-first 5 slaves /16, 8-bit LSB-first 1 slave /8).
module tb_spi_mnrch_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        wrt_a = 1'b0;
   logic [15:0] wd_a = '0;
   logic [2:0]  sel_a = '0;
   logic        keep_a = 1'b0;
   logic        miso_a = 1'b0;
   logic        sclk_a, mosi_a, busy_a, done_a;
   logic [4:0]  ssn_a;
   logic [15:0] rd_a;

   logic        wrt_b = 1'b0;
   logic [7:0]  wd_b = '0;
   logic [0:0]  sel_b = '0;
   logic        keep_b = 1'b0;
   logic        miso_b = 1'b0;
   logic        sclk_b, mosi_b, busy_b, done_b;
   logic [0:0]  ssn_b;
   logic [7:0]  rd_b;

   int n_cmp = 0;
   int n_err = 0;

   spi_mnrch_gen #(
      .DATA_W(16), .DIV_LOG2(4), .NUM_SS(5), .LSB_FIRST(0)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .wrt(wrt_a), .wrt_data(wd_a),
      .ss_sel(sel_a), .keep_ss(keep_a), .MISO(miso_a),
      .SCLK(sclk_a), .MOSI(mosi_a), .SS_N(ssn_a),
      .busy(busy_a), .done(done_a), .rd_data(rd_a)
   );

   spi_mnrch_gen #(
      .DATA_W(8), .DIV_LOG2(3), .NUM_SS(1), .LSB_FIRST(1)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .wrt(wrt_b), .wrt_data(wd_b),
      .ss_sel(sel_b), .keep_ss(keep_b), .MISO(miso_b),
      .SCLK(sclk_b), .MOSI(mosi_b), .SS_N(ssn_b),
      .busy(busy_b), .done(done_b), .rd_data(rd_b)
   );

   // Slave model for A: bit k is presented after the k-th SCLK fall and
   // MOSI is collected at each SCLK rise, MSB first. Returns observations.
   task automatic frame_a(
      input  logic [15:0] tx, input logic [2:0] sel, input logic keep,
      input  logic [15:0] sw, input int junk,
      output int lat, output logic [15:0] mo, output int falls,
      output int f1, output int fl, output logic [4:0] s_and,
      output logic [4:0] s_or, output logic bsy);
      int   rises;
      logic prv;
      @(negedge clk);
      wrt_a = 1'b1; wd_a = tx; sel_a = sel; keep_a = keep;
      @(negedge clk);
      wrt_a = 1'b0; wd_a = 16'($urandom);
      sel_a = 3'($urandom_range(0, 7)); keep_a = 1'($urandom_range(0, 1));
      lat = 0; mo = '0; falls = 0; rises = 0; f1 = -1; fl = -1;
      s_and = '1; s_or = '0; bsy = 1'b1; prv = 1'b1;
      while (done_a !== 1'b1 && lat < 2000) begin
         if (prv && !sclk_a) begin
            if (falls == 0) f1 = lat;
            fl = lat;
            if (falls < 16) miso_a = sw[15 - falls];
            falls++;
         end
         if (!prv && sclk_a) begin
            if (rises < 16) mo[15 - rises] = mosi_a;
            rises++;
         end
         prv = sclk_a;
         s_and &= ssn_a; s_or |= ssn_a; bsy &= busy_a;
         if (lat == junk) begin
            wrt_a = 1'b1; wd_a = 16'($urandom);
            sel_a = 3'($urandom_range(0, 7));
            keep_a = 1'($urandom_range(0, 1));
         end else begin
            wrt_a = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      wrt_a = 1'b0;
   endtask

   // Same slave model for B, LSB first.
   task automatic frame_b(
      input  logic [7:0] tx, input logic [0:0] sel, input logic [7:0] sw,
      output int lat, output logic [7:0] mo, output int falls,
      output int f1, output int fl, output logic s_and, output logic s_or);
      int   rises;
      logic prv;
      @(negedge clk);
      wrt_b = 1'b1; wd_b = tx; sel_b = sel; keep_b = 1'b0;
      @(negedge clk);
      wrt_b = 1'b0; wd_b = 8'($urandom);
      lat = 0; mo = '0; falls = 0; rises = 0; f1 = -1; fl = -1;
      s_and = 1'b1; s_or = 1'b0; prv = 1'b1;
      while (done_b !== 1'b1 && lat < 1000) begin
         if (prv && !sclk_b) begin
            if (falls == 0) f1 = lat;
            fl = lat;
            if (falls < 8) miso_b = sw[falls];
            falls++;
         end
         if (!prv && sclk_b) begin
            if (rises < 8) mo[rises] = mosi_b;
            rises++;
         end
         prv = sclk_b;
         s_and &= ssn_b[0]; s_or |= ssn_b[0];
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (ssn_a !== 5'h1F) begin n_err++;
         $display("FAIL rst_ssn_a got %h want 1f", ssn_a); end
      n_cmp++; if (sclk_a !== 1'b1) begin n_err++;
         $display("FAIL rst_sclk_a got %b want 1", sclk_a); end
      n_cmp++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin n_err++;
         $display("FAIL rst_flags_a got %b%b want 00", done_a, busy_a); end
      n_cmp++; if (rd_a !== 16'h0 || mosi_a !== 1'b0) begin n_err++;
         $display("FAIL rst_sr_a got %h/%b want 0000/0", rd_a, mosi_a); end
      n_cmp++; if (ssn_b !== 1'b1 || sclk_b !== 1'b1) begin n_err++;
         $display("FAIL rst_pins_b got %b%b want 11", ssn_b, sclk_b); end
      n_cmp++; if (done_b !== 1'b0 || rd_b !== 8'h0) begin n_err++;
         $display("FAIL rst_st_b got %b/%h want 0/00", done_b, rd_b); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_frames_a();
      logic [15:0] tx, sw, mo;
      logic [4:0]  sa, so, ex;
      logic [2:0]  sel;
      logic        bsy;
      int          lat, fa, f1, fl;
      for (int i = 0; i < 6; i++) begin
         tx  = (i == 0) ? 16'hA5C3 : 16'($urandom);
         sw  = (i == 0) ? tx : 16'($urandom);
         sel = 3'($urandom_range(0, 4));
         ex  = 5'h1F; ex[sel] = 1'b0;
         frame_a(tx, sel, 1'b0, sw, -1, lat, mo, fa, f1, fl, sa, so, bsy);
         n_cmp++; if (lat !== 261) begin n_err++;
            $display("FAIL a_lat[%0d] got %0d want 261", i, lat); end
         n_cmp++; if (mo !== tx) begin n_err++;
            $display("FAIL a_mosi[%0d] got %h want %h", i, mo, tx); end
         n_cmp++; if (rd_a !== sw) begin n_err++;
            $display("FAIL a_rd[%0d] got %h want %h", i, rd_a, sw); end
         n_cmp++; if (fa !== 16 || f1 !== 5 || fl - f1 !== 240) begin
            n_err++;
            $display("FAIL a_sclk[%0d] got n=%0d f1=%0d span=%0d want 16/5/240",
                     i, fa, f1, fl - f1); end
         n_cmp++; if (sa !== ex || so !== ex) begin n_err++;
            $display("FAIL a_ss[%0d] got %h/%h want %h", i, sa, so, ex); end
         n_cmp++; if (bsy !== 1'b1 || ssn_a !== 5'h1F) begin n_err++;
            $display("FAIL a_end[%0d] got busy=%b ss=%h want 1/1f",
                     i, bsy, ssn_a); end
         repeat (3) @(negedge clk);
         n_cmp++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin n_err++;
            $display("FAIL a_hold_done[%0d] got %b%b want 10",
                     i, done_a, busy_a); end
      end
   endtask

   task automatic test_out_of_range();
      logic [15:0] tx, sw, mo;
      logic [4:0]  sa, so;
      logic [7:0]  mb;
      logic        bsy, ba, bo;
      int          lat, fa, f1, fl;
      for (int s = 5; s < 8; s += 2) begin
         tx = 16'($urandom); sw = 16'($urandom);
         frame_a(tx, 3'(s), 1'b0, sw, -1, lat, mo, fa, f1, fl, sa, so, bsy);
         n_cmp++; if (sa !== 5'h1F || so !== 5'h1F) begin n_err++;
            $display("FAIL oor_ss[%0d] got %h/%h want 1f", s, sa, so); end
         n_cmp++; if (lat !== 261 || rd_a !== sw) begin n_err++;
            $display("FAIL oor_done[%0d] got lat=%0d rd=%h want 261/%h",
                     s, lat, rd_a, sw); end
      end
      frame_b(8'($urandom), 1'b1, 8'h3C, lat, mb, fa, f1, fl, ba, bo);
      n_cmp++; if (ba !== 1'b1 || bo !== 1'b1) begin n_err++;
         $display("FAIL oor_ss_b got %b/%b want 1", ba, bo); end
      n_cmp++; if (lat !== 67 || rd_b !== 8'h3C) begin n_err++;
         $display("FAIL oor_done_b got lat=%0d rd=%h want 67/3c", lat, rd_b); end
   endtask

   task automatic test_burst();
      logic [15:0] t1, s1, t2, s2, mo;
      logic [4:0]  sa, so, ga, go, ex;
      logic        bsy;
      int          lat, fa, f1, fl;
      ex = 5'b10111;
      t1 = 16'($urandom); s1 = 16'($urandom);
      frame_a(t1, 3'd3, 1'b1, s1, -1, lat, mo, fa, f1, fl, sa, so, bsy);
      n_cmp++; if (lat !== 261 || rd_a !== s1 || mo !== t1) begin n_err++;
         $display("FAIL burst1 got lat=%0d rd=%h mo=%h want 261/%h/%h",
                  lat, rd_a, mo, s1, t1); end
      n_cmp++; if (sa !== ex || so !== ex || ssn_a !== ex) begin n_err++;
         $display("FAIL burst1_ss got %h/%h end=%h want %h",
                  sa, so, ssn_a, ex); end
      ga = '1; go = '0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         ga &= ssn_a; go |= ssn_a;
         n_cmp++; if (done_a !== 1'b1 || busy_a !== 1'b0 || sclk_a !== 1'b1)
         begin n_err++;
            $display("FAIL hold_st[%0d] got d=%b b=%b s=%b want 1/0/1",
                     k, done_a, busy_a, sclk_a); end
      end
      n_cmp++; if (ga !== ex || go !== ex) begin n_err++;
         $display("FAIL hold_ss got %h/%h want %h", ga, go, ex); end
      t2 = 16'($urandom); s2 = 16'($urandom);
      frame_a(t2, 3'd0, 1'b0, s2, -1, lat, mo, fa, f1, fl, sa, so, bsy);
      n_cmp++; if (lat !== 261 || rd_a !== s2 || mo !== t2) begin n_err++;
         $display("FAIL burst2 got lat=%0d rd=%h mo=%h want 261/%h/%h",
                  lat, rd_a, mo, s2, t2); end
      n_cmp++; if (sa !== ex || so !== ex || bsy !== 1'b1) begin n_err++;
         $display("FAIL burst2_ss got %h/%h busy=%b want %h/1",
                  sa, so, bsy, ex); end
      n_cmp++; if (ssn_a !== 5'h1F) begin n_err++;
         $display("FAIL burst2_end got %h want 1f", ssn_a); end
   endtask

   task automatic test_busy_wrt();
      logic [15:0] tx, sw, mo;
      logic [4:0]  sa, so;
      logic        bsy;
      int          lat, fa, f1, fl, j;
      j  = $urandom_range(10, 250);
      tx = 16'($urandom); sw = 16'($urandom);
      frame_a(tx, 3'd1, 1'b0, sw, j, lat, mo, fa, f1, fl, sa, so, bsy);
      n_cmp++; if (lat !== 261 || mo !== tx || rd_a !== sw) begin n_err++;
         $display("FAIL busy_wrt got lat=%0d mo=%h rd=%h want 261/%h/%h",
                  lat, mo, rd_a, tx, sw); end
      tx = 16'($urandom); sw = 16'($urandom);
      frame_a(tx, 3'd4, 1'b0, sw, 260, lat, mo, fa, f1, fl, sa, so, bsy);
      n_cmp++; if (lat !== 261 || rd_a !== sw) begin n_err++;
         $display("FAIL done_edge_wrt got lat=%0d rd=%h want 261/%h",
                  lat, rd_a, sw); end
      @(negedge clk);
      n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b1 || ssn_a !== 5'h1F)
      begin n_err++;
         $display("FAIL done_edge_ign got b=%b d=%b ss=%h want 0/1/1f",
                  busy_a, done_a, ssn_a); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] tx, sw, mo;
      logic [4:0]  sa, so;
      logic        bsy;
      int          lat, fa, f1, fl;
      @(negedge clk);
      wrt_a = 1'b1; wd_a = 16'($urandom); sel_a = 3'd1; keep_a = 1'b1;
      @(negedge clk);
      wrt_a = 1'b0;
      repeat (117) @(negedge clk);
      n_cmp++; if (busy_a !== 1'b1 || ssn_a !== 5'b11101 || sclk_a !== 1'b0)
      begin n_err++;
         $display("FAIL pre_rst got b=%b ss=%h s=%b want 1/1d/0",
                  busy_a, ssn_a, sclk_a); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++; if (ssn_a !== 5'h1F || sclk_a !== 1'b1) begin n_err++;
         $display("FAIL mid_rst_pins got ss=%h s=%b want 1f/1", ssn_a, sclk_a); end
      n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0 || rd_a !== 16'h0)
      begin n_err++;
         $display("FAIL mid_rst_st got b=%b d=%b rd=%h want 0/0/0",
                  busy_a, done_a, rd_a); end
      repeat (20) @(negedge clk);
      n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0 || ssn_a !== 5'h1F)
      begin n_err++;
         $display("FAIL post_rst_idle got b=%b d=%b ss=%h want 0/0/1f",
                  busy_a, done_a, ssn_a); end
      tx = 16'($urandom); sw = 16'($urandom);
      frame_a(tx, 3'd2, 1'b0, sw, -1, lat, mo, fa, f1, fl, sa, so, bsy);
      n_cmp++; if (lat !== 261 || mo !== tx || rd_a !== sw) begin n_err++;
         $display("FAIL post_rst_frame got lat=%0d mo=%h rd=%h want 261/%h/%h",
                  lat, mo, rd_a, tx, sw); end
   endtask

   task automatic test_lsb_b();
      logic [7:0] tx, sw, mo;
      logic       ba, bo;
      int         lat, fa, f1, fl;
      frame_b(8'h01, 1'b0, 8'hFF, lat, mo, fa, f1, fl, ba, bo);
      n_cmp++; if (mo !== 8'h01 || rd_b !== 8'hFF) begin n_err++;
         $display("FAIL lsb_fix got mo=%h rd=%h want 01/ff", mo, rd_b); end
      n_cmp++; if (lat !== 67 || fa !== 8 || f1 !== 3 || fl - f1 !== 56)
      begin n_err++;
         $display("FAIL lsb_tim got lat=%0d n=%0d f1=%0d span=%0d want 67/8/3/56",
                  lat, fa, f1, fl - f1); end
      n_cmp++; if (ba !== 1'b0 || bo !== 1'b0 || ssn_b !== 1'b1) begin
         n_err++;
         $display("FAIL lsb_ss got %b/%b end=%b want 0/0/1", ba, bo, ssn_b); end
      for (int i = 0; i < 4; i++) begin
         tx = 8'($urandom); sw = 8'($urandom);
         frame_b(tx, 1'b0, sw, lat, mo, fa, f1, fl, ba, bo);
         n_cmp++; if (lat !== 67 || mo !== tx || rd_b !== sw) begin n_err++;
            $display("FAIL lsb_rnd[%0d] got lat=%0d mo=%h rd=%h want 67/%h/%h",
                     i, lat, mo, rd_b, tx, sw); end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_frames_a();
      test_out_of_range();
      test_burst();
      test_busy_wrt();
      test_lsb_b();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
